icache_2word: RTL

- Direct-mapped, read-only instruction cache between the pipelined datapath fetch port and the memory controller's instruction port.
- Serves the datapath's instruction fetch requests (`imemREN`, `imemaddr`) with single-cycle hits; `ihit` gates the fetch-stage PC and latch enable.
- On a miss, fetches a 2-word block over the memory controller's `iREN`/`iaddr`/`iwait`/`iload` handshake.
- Keeps hit/miss statistics for end-of-run reporting.

---
 rtl/icache_2word_if.sv | 13 +
 rtl/icache_2word.sv | 66 ++++++
 2 files changed

// File: rtl/icache_2word_if.sv
// icache_2word_if: fetch-port and memory-port signals shared by the datapath, icache and memory controller
interface icache_2word_if #(parameter int WORD_W = 32);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  modport master (output imemREN, imemaddr, iwait, iload, input ihit, imemload, iREN, iaddr);
  modport slave (input imemREN, imemaddr, iwait, iload, output ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_2word.sv
// icache_2word: direct-mapped read-only instruction cache with 2-word blocks and hit/miss counters
module icache_2word #(
  parameter int SETS   = 8,
  parameter int WORD_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          halt,
  icache_2word_if.slave ic,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 3;
  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;
  state_t state, next_state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [WORD_W-1:0] data0 [SETS];
  logic [WORD_W-1:0] data1 [SETS];
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic              hit, miss, ack;
  assign req_tag = ic.imemaddr[WORD_W-1:IDX_W+3];
  assign req_idx = ic.imemaddr[IDX_W+2:3];
  assign hit  = ic.imemREN && state == IDLE && valid[req_idx] && tags[req_idx] == req_tag;
  assign miss = ic.imemREN && state == IDLE && !hit;
  assign ack  = state != IDLE && !ic.iwait;
  assign ic.ihit     = hit;
  assign ic.imemload = hit ? (ic.imemaddr[2] ? data1[req_idx] : data0[req_idx]) : '0;
  // fills run from the latched miss address so a redirect cannot disturb them
  assign ic.iREN  = state != IDLE;
  assign ic.iaddr = ic.iREN ? {miss_tag, miss_idx, state == FETCH1, 2'b00} : '0;
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = miss ? FETCH0 : IDLE;
    else if (ack) next_state = state == FETCH0 ? FETCH1 : IDLE;
  end
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      miss_tag   <= '0;
      miss_idx   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (miss) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
      end
      if (state == FETCH0 && ack) valid[miss_idx] <= 1'b0;
      if (state == FETCH1 && ack) valid[miss_idx] <= 1'b1;
      if (hit && !halt) hit_count <= hit_count + 32'd1;
      if (miss && !halt) miss_count <= miss_count + 32'd1;
    end
  end
  always_ff @(posedge CLK) begin
    if (ack && state == FETCH0) data0[miss_idx] <= ic.iload;
    if (ack && state == FETCH1) begin
      data1[miss_idx] <= ic.iload;
      tags[miss_idx]  <= miss_tag;
    end
  end
endmodule
